// File: rtl/main_seq_detector_pkg.sv
// Shared widths, types and FSM state encoding for the nibble sequence detector.
package main_pkg;

    localparam int NIBBLE_W = 4;
    localparam int DEPTH    = 4;
    localparam int SUM_W    = 64;
    localparam int PAT_W    = 16;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        COLLECT,
        ARMED,
        FOUND
    } state_e;

endpackage : main_pkg

// File: rtl/main_seq_detector_nibble_window.sv
// Four-entry sliding nibble window with a saturating fill count.
// match_o compares the window as it will be after the current shift,
// so the completing nibble is matched on the same edge that accepts it.
module nibble_window
    import main_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept_i,
    input  nibble_t          nibble_i,
    input  logic [PAT_W-1:0] pat_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             match_o
);

    // Entry 0 is the oldest nibble and sits in bits [3:0], so the packed
    // window lines up bit-for-bit with the pattern.
    logic [DEPTH-1:0][NIBBLE_W-1:0] win_q, win_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    // Post-shift window, saturating count and the match it produces.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        win_d   = win_q;
        cnt_d   = cnt_q;
        if (accept_i) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[DEPTH-1] = nibble_i;
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        match_o = accept_i && (cnt_d == CNT_W'(DEPTH)) && (win_d == pat_i);
    end

    // Window and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the window is a handful of flops, not a RAM, so it is safe to clear it on reset.
        if (!rst_n) begin
            win_q <= '0;
            cnt_q <= '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : nibble_window

// File: rtl/main_seq_detector.sv
// Nibble sequence detector: accepts one nibble per read rising edge, keeps a
// running 64-bit sum, and raises a sticky find once the last four accepted
// nibbles equal the pattern latched at the first accept.
module main_seq_detector
    import main_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [PAT_W-1:0] cypher,
    input  nibble_t          four_bit_input,
    input  logic             read,
    output logic             find,
    output logic [SUM_W-1:0] additionresult
);

    logic             read_q;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic             match;
    logic             accept;

    // One accept per read rising edge; everything freezes once found.
    assign accept = read & ~read_q & ~find;

    nibble_window u_window (
        .clk      (clock),
        .rst_n    (reset),
        .accept_i (accept),
        .nibble_i (four_bit_input),
        .pat_i    (pat_q),
        .cnt_o    (cnt),
        .match_o  (match)
    );

    // Pattern latch, running sum and state transitions.
    always_comb begin
        pat_d   = pat_q;
        sum_d   = sum_q;
        state_d = state_q;
        if (accept) begin
            // The count is zero only before the first accept after reset.
            if (cnt == '0) begin
                pat_d = cypher;
            end
            sum_d = sum_q + SUM_W'(four_bit_input);
        end
        unique case (state_q)
            COLLECT: begin
                if (match) begin
                    state_d = FOUND;
                end else if (accept && cnt == CNT_W'(DEPTH - 1)) begin
                    state_d = ARMED;
                end
            end
            ARMED:   if (match) state_d = FOUND;
            FOUND:   state_d = FOUND;
            default: state_d = COLLECT;
        endcase
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            read_q  <= 1'b0;
            pat_q   <= '0;
            sum_q   <= '0;
            state_q <= COLLECT;
        end else begin
            read_q  <= read;
            pat_q   <= pat_d;
            sum_q   <= sum_d;
            state_q <= state_d;
        end
    end

    assign find           = (state_q == FOUND);
    assign additionresult = sum_q;

endmodule : main_seq_detector

// File: tb/tb_main_seq_detector.sv
// Self-checking bench for main_seq_detector: directed scenarios plus random
// read/nibble/cypher traffic compared against a queue-based reference model.
module tb_main_seq_detector;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cypher = '0;
    logic [3:0]  four_bit_input = '0;
    logic        read = 1'b0;
    logic        find;
    logic [63:0] additionresult;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          hist[$];
    logic [63:0] m_sum;
    logic [15:0] m_pat;
    bit          m_have_pat;
    bit          m_found;
    bit          m_prev_read;

    main_seq_detector dut (
        .clock          (clock),
        .reset          (reset),
        .cypher         (cypher),
        .four_bit_input (four_bit_input),
        .read           (read),
        .find           (find),
        .additionresult (additionresult)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        m_sum       = '0;
        m_pat       = '0;
        m_have_pat  = 0;
        m_found     = 0;
        m_prev_read = 0;
    endtask

    // Behaviour of one accepted nibble: last four accepted must equal the
    // latched pattern, oldest nibble against the low nibble of the pattern.
    task automatic model_accept(input int n);
        if (m_found) return;
        if (!m_have_pat) begin
            m_pat      = cypher;
            m_have_pat = 1;
        end
        hist.push_back(n);
        if (hist.size() > 4) void'(hist.pop_front());
        m_sum = m_sum + 64'(n);
        if (hist.size() == 4 &&
            hist[0] == int'(m_pat[3:0])  && hist[1] == int'(m_pat[7:4]) &&
            hist[2] == int'(m_pat[11:8]) && hist[3] == int'(m_pat[15:12]))
            m_found = 1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        read  = 1'b0;
        reset = 1'b0;
        #2;
        model_clear();
        check({tag, "_rst_find"}, 64'(find), 64'(m_found));
        check({tag, "_rst_sum"}, additionresult, m_sum);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One read pulse: find must already reflect the nibble one clock after
    // read is sampled high.
    task automatic send(input string tag, input logic [3:0] n);
        four_bit_input = n;
        read           = 1'b1;
        if (!m_prev_read && !m_found) model_accept(int'(n));
        m_prev_read = 1;
        @(negedge clock);
        check({tag, "_find"}, 64'(find), 64'(m_found));
        check({tag, "_sum"}, additionresult, m_sum);
        read        = 1'b0;
        m_prev_read = 0;
        @(negedge clock);
    endtask

    task automatic send_list(input string tag, input int q[$]);
        foreach (q[i]) send(tag, 4'(q[i]));
    endtask

    initial begin
        int seq030[$] = '{0, 2, 15, 2, 3, 5, 9, 0, 2, 1, 1, 2, 3, 4};
        int pre[$]    = '{0, 2, 15, 2, 3, 5, 9, 0, 2, 1, 1, 2, 3};

        model_clear();

        // Reset state and main example
        cypher = 16'h4321;
        do_reset("r030");
        send_list("pre030", pre);
        check("pre030_nofind", 64'(find), 64'd0);
        send("last030", 4'd4);
        check("s030_find", 64'(find), 64'd1);
        check("s030_sum", additionresult, 64'd49);

        // Long read level gives a single accept
        do_reset("r031");
        four_bit_input = 4'd5;
        read           = 1'b1;
        model_accept(5);
        repeat (30) @(negedge clock);
        check("s031_sum", additionresult, m_sum);
        check("s031_cnt", 64'(dut.u_window.cnt_q), 64'(hist.size()));
        read = 1'b0;
        @(negedge clock);

        // Match on 4th nibble, then reads ignored
        cypher = 16'h1111;
        do_reset("r032");
        send_list("s032a", '{1, 1, 1});
        check("s032_three", 64'(find), 64'd0);
        send("s032b", 4'd1);
        check("s032_four", 64'(find), 64'd1);
        send("s032c", 4'd7);
        check("s032_sticky_sum", additionresult, 64'd4);
        check("s032_sticky_find", 64'(find), 64'd1);

        // Cypher latched at first accept
        cypher = 16'h4321;
        do_reset("r033");
        send("s033a", 4'd9);
        cypher = 16'h0000;
        send_list("s033b", '{1, 2, 3, 4});
        check("s033_find", 64'(find), 64'd1);

        // Mid-stream reset discards progress
        cypher = 16'h4321;
        do_reset("r034");
        send_list("s034a", '{1, 2, 3});
        #2 reset = 1'b0;
        #1;
        model_clear();
        check("s034_mid_find", 64'(find), 64'd0);
        check("s034_mid_sum", additionresult, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        send("s034b", 4'd4);
        check("s034_lone4", 64'(find), 64'd0);
        do_reset("r034b");
        send_list("s034c", '{1, 2, 3, 4});
        check("s034_find", 64'(find), 64'd1);
        check("s034_sum", additionresult, 64'd10);

        // Sum wrap modulo 2^64
        cypher = 16'h0000;
        do_reset("r035");
        send("s035a", 4'd15);
        force dut.sum_q = 64'hFFFF_FFFF_FFFF_FFF0;
        #1 release dut.sum_q;
        m_sum = 64'hFFFF_FFFF_FFFF_FFF0;
        @(negedge clock);
        check("s035_preload", additionresult, m_sum);
        send_list("s035b", '{15, 15, 15});
        check("s035_wrap", additionresult, 64'h0000_0000_0000_001D);
        check("s035_nofind", 64'(find), 64'd0);

        // Random traffic against the model
        for (int round = 0; round < 20; round++) begin
            cypher = {2'b0, 2'($urandom_range(0, 1)), 2'b0, 2'($urandom_range(0, 1)),
                      2'b0, 2'($urandom_range(0, 1)), 2'b0, 2'($urandom_range(0, 1))};
            do_reset("rnd_rst");
            @(negedge clock);
            for (int cyc = 0; cyc < 150; cyc++) begin
                logic r;
                logic [3:0] n;
                r = 1'($urandom_range(0, 1));
                n = 4'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) cypher = 16'($urandom);
                read           = r;
                four_bit_input = n;
                if (r && !m_prev_read && !m_found) model_accept(int'(n));
                m_prev_read = r;
                @(negedge clock);
                check("rnd_find", 64'(find), 64'(m_found));
                check("rnd_sum", additionresult, m_sum);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_main_seq_detector
